misr_bist_ctrl: RTL and testbench

//  Upstream BIST sequencer for the misr compactor. Generates pseudo-random test patterns with an internal LFSR (TPG).

---
 rtl/misr_bist_ctrl.sv | 119 +++++++++++
 tb/tb_misr_bist_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_bist_ctrl.sv
// BIST sequencer: LFSR pattern generator drives a MISR for PATTERN_COUNT cycles, then checks the signature.
// Latency: misr_en/misr_dat_in are decoded from state; done rises 2 edges after the last MISR update edge.
// Backpressure: optional pause input (build with MISR_BIST_PAUSE_EN) stalls RUN without changing the signature.
module misr_bist_ctrl #(
  parameter int                     LFSR_LENGTH   = 4,
  parameter logic [LFSR_LENGTH-1:0] TPG_PRIM_POLY = 4'b1101,
  parameter logic [LFSR_LENGTH-1:0] TPG_SEED_VAL  = 4'b0001,
  parameter int                     PATTERN_COUNT = 16,
  parameter logic [LFSR_LENGTH-1:0] GOLDEN_SIG    = 4'b0000
) (
  input  logic                   lfsr_clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [LFSR_LENGTH-1:0] misr_state_in,
`ifdef MISR_BIST_PAUSE_EN
  input  logic                   pause,
`endif
  output logic                   misr_en,
  output logic [LFSR_LENGTH-1:0] misr_dat_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass
);

  // Counter is wide enough to hold PATTERN_COUNT itself, so it never wraps within a run.
  localparam int CNT_W = (PATTERN_COUNT < 1) ? 1 : $clog2(PATTERN_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t                   state;
  logic [LFSR_LENGTH-1:0]   tpg;
  logic [LFSR_LENGTH-1:0]   tpg_next;
  logic                     tpg_fb;
  logic [CNT_W-1:0]         cnt;
  logic                     run_st;
  logic                     pause_i;

`ifdef MISR_BIST_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // Pattern outputs are combinational from state so the MISR sees each pattern in its RUN cycle.
  assign run_st      = (state == S_RUN);
  assign misr_en     = run_st & ~pause_i;
  assign misr_dat_in = run_st ? tpg : '0;

  // TPG feedback: MSB XOR every tapped interior bit (end bits excluded from the tap mask).
  always_comb begin
    tpg_fb = tpg[LFSR_LENGTH-1];
    for (int i = 1; i < LFSR_LENGTH - 1; i++) begin
      if (TPG_PRIM_POLY[i]) begin
        tpg_fb = tpg_fb ^ tpg[i];
      end
    end
    tpg_next = {tpg[LFSR_LENGTH-2:0], tpg_fb};
  end

  // Sequencer FSM with registered status outputs; DONE is terminal until resetn.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      tpg   <= TPG_SEED_VAL;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (PATTERN_COUNT == 0) begin
              state <= S_WAIT;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A paused cycle holds both the pattern and the count.
          if (misr_en) begin
            tpg <= tpg_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Gives the final MISR update one cycle to appear on misr_state_in.
          busy  <= 1'b0;
          state <= S_CMP;
        end
        S_CMP: begin
          pass  <= (misr_state_in == GOLDEN_SIG);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Self-checking bench: three controllers (matching golden, flipped golden, zero-length run), each with a MISR model.
// Latency: patterns checked in-cycle; pass checked when done rises.
// Backpressure: pause exercised only when built with MISR_BIST_PAUSE_EN.
module tb_misr_bist_ctrl;

  logic       lfsr_clk = 1'b0;
  logic       resetn;
  logic       start;
`ifdef MISR_BIST_PAUSE_EN
  logic       pause;
`endif

  logic       a_en, b_en, c_en;
  logic [3:0] a_dat, b_dat, c_dat;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;
  logic       a_pass, b_pass, c_pass;
  logic [3:0] misr_a, misr_b, misr_c;

  int n_pass  = 0;
  int n_total = 0;

  // Hand-derived TPG sequence for taps 1101, seed 0001 (fb = t[3]^t[2]).
  logic [3:0] pat_tab [16];

  logic [3:0] exp_dat_q [$];
  bit         exp_pass_a [$];
  bit         exp_pass_b [$];
  bit         exp_pass_c [$];

  int         c_en_seen = 0;
  logic       a_done_q = 1'b0, b_done_q = 1'b0, c_done_q = 1'b0;

  always #5 lfsr_clk = ~lfsr_clk;

  // Signature of the rotate-left-xor MISR model below, seed 1011, over the 16 patterns: 1010.
  misr_bist_ctrl #(.PATTERN_COUNT(16), .GOLDEN_SIG(4'b1010)) u_a (
    .lfsr_clk(lfsr_clk), .resetn(resetn), .start(start), .misr_state_in(misr_a),
`ifdef MISR_BIST_PAUSE_EN
    .pause(pause),
`endif
    .misr_en(a_en), .misr_dat_in(a_dat), .busy(a_busy), .done(a_done), .pass(a_pass));

  misr_bist_ctrl #(.PATTERN_COUNT(16), .GOLDEN_SIG(4'b1011)) u_b (
    .lfsr_clk(lfsr_clk), .resetn(resetn), .start(start), .misr_state_in(misr_b),
`ifdef MISR_BIST_PAUSE_EN
    .pause(pause),
`endif
    .misr_en(b_en), .misr_dat_in(b_dat), .busy(b_busy), .done(b_done), .pass(b_pass));

  misr_bist_ctrl #(.PATTERN_COUNT(0), .GOLDEN_SIG(4'b1011)) u_c (
    .lfsr_clk(lfsr_clk), .resetn(resetn), .start(start), .misr_state_in(misr_c),
`ifdef MISR_BIST_PAUSE_EN
    .pause(pause),
`endif
    .misr_en(c_en), .misr_dat_in(c_dat), .busy(c_busy), .done(c_done), .pass(c_pass));

  function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [3:0] d);
    return {s[2:0], s[3]} ^ d;
  endfunction

  // MISR models: seed 1011 on resetn, compact misr_dat_in when misr_en.
  always @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      misr_a <= 4'b1011;
      misr_b <= 4'b1011;
      misr_c <= 4'b1011;
    end else begin
      if (a_en) misr_a <= misr_step(misr_a, a_dat);
      if (b_en) misr_b <= misr_step(misr_b, b_dat);
      if (c_en) misr_c <= misr_step(misr_c, c_dat);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Scoreboard monitor: pops expectations whenever a DUT presents a pattern or raises done.
  always @(negedge lfsr_clk) begin
    logic [3:0] e;
    bit         ep;
    if (a_en) begin
      if (exp_dat_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_dat: misr_en high with dat %0h but no pattern expected (t=%0t)", a_dat, $time);
      end else begin
        e = exp_dat_q.pop_front();
        chk("sb_dat", a_dat, e);
      end
    end
    if (a_done && !a_done_q) begin
      if (exp_pass_a.size() == 0) begin
        n_total++;
        $display("FAIL sb_pass_a: done rose with pass %0b but none expected", a_pass);
      end else begin
        ep = exp_pass_a.pop_front();
        chk("sb_pass_a", a_pass, ep);
      end
    end
    if (b_done && !b_done_q) begin
      if (exp_pass_b.size() == 0) begin
        n_total++;
        $display("FAIL sb_pass_b: done rose with pass %0b but none expected", b_pass);
      end else begin
        ep = exp_pass_b.pop_front();
        chk("sb_pass_b", b_pass, ep);
      end
    end
    if (c_done && !c_done_q) begin
      if (exp_pass_c.size() == 0) begin
        n_total++;
        $display("FAIL sb_pass_c: done rose with pass %0b but none expected", c_pass);
      end else begin
        ep = exp_pass_c.pop_front();
        chk("sb_pass_c", c_pass, ep);
      end
    end
    if (c_en) c_en_seen++;
    a_done_q = a_done;
    b_done_q = b_done;
    c_done_q = c_done;
  end

  task automatic push_run(input bit full);
    for (int i = 0; i < 16; i++) exp_dat_q.push_back(pat_tab[i]);
    if (full) begin
      exp_pass_a.push_back(1'b1);
      exp_pass_b.push_back(1'b0);
    end
    exp_pass_c.push_back(1'b1);
  endtask

  // One full run: pulse start, then walk cycles checking patterns, pause freeze, WAIT and done timing.
  task automatic run_full(input int pause_at);
    int idx, first_en, last_en, done_cyc, paused;
    idx = 0; first_en = -1; last_en = -1; done_cyc = -1; paused = 0;
    @(posedge lfsr_clk); #1 start = 1'b1;
    @(posedge lfsr_clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
      if (cyc > 0) begin
        @(posedge lfsr_clk); #1;
      end
`ifdef MISR_BIST_PAUSE_EN
      pause = (pause_at >= 0 && cyc >= pause_at && cyc < pause_at + 3);
      #1;
`endif
      if (a_en) begin
        if (first_en < 0) first_en = cyc;
        if (idx < 5) begin
          chk("run_pattern", a_dat, pat_tab[idx]);
          chk("run_busy", a_busy, 1);
        end
        last_en = cyc;
        idx++;
      end else if (a_busy && idx > 0 && idx < 16) begin
        // RUN with misr_en low: pattern must be frozen at the next unused value.
        paused++;
        chk("pause_dat_frozen", a_dat, pat_tab[idx]);
      end
      if (idx == 16 && cyc == last_en + 1) begin
        chk("wait_busy", a_busy, 1);
        chk("wait_done", a_done, 0);
      end
      if (a_done) done_cyc = cyc;
    end
`ifdef MISR_BIST_PAUSE_EN
    pause = 1'b0;
`endif
    chk("done_seen", (done_cyc >= 0), 1);
    chk("en_count", idx, 16);
    chk("en_span", last_en - first_en + 1, 16 + ((pause_at >= 0) ? 3 : 0));
    chk("paused_cycles", paused, (pause_at >= 0) ? 3 : 0);
    // WAIT then CMP, each one cycle: done is first seen three samples after the last misr_en.
    chk("done_latency", done_cyc - last_en, 3);
  endtask

  initial begin
    pat_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    resetn = 1'b0;
    start  = 1'b0;
`ifdef MISR_BIST_PAUSE_EN
    pause  = 1'b0;
`endif
    repeat (3) @(posedge lfsr_clk);
    #1;
    chk("rst_en", a_en, 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);

    // Run 1: default sequence, matching and flipped golden, zero-length run.
    @(posedge lfsr_clk); #1 resetn = 1'b1;
    push_run(1'b1);
    run_full(-1);
    repeat (2) @(posedge lfsr_clk);

    // start pulses in DONE are ignored.
    #1 start = 1'b1;
    @(posedge lfsr_clk); #1 start = 1'b0;
    repeat (4) @(posedge lfsr_clk);
    #1;
    chk("done_hold_a", a_done, 1);
    chk("done_hold_pass_a", a_pass, 1);
    chk("done_hold_b", b_done, 1);
    chk("done_hold_pass_b", b_pass, 0);
    chk("done_hold_c", c_done, 1);
    chk("done_hold_pass_c", c_pass, 1);
    chk("done_en_low", a_en, 0);
    chk("done_busy_low", a_busy, 0);

    // Run 2: abort with reset at RUN cycle 7.
    resetn = 1'b0;
    repeat (2) @(posedge lfsr_clk);
    #1 resetn = 1'b1;
    push_run(1'b0);
    @(posedge lfsr_clk); #1 start = 1'b1;
    @(posedge lfsr_clk); #1 start = 1'b0;
    repeat (6) @(posedge lfsr_clk);
    #2;
    chk("abort_pre_dat", a_dat, pat_tab[6]);
    chk("abort_pre_en", a_en, 1);
    resetn = 1'b0;
    #1;
    chk("abort_en", a_en, 0);
    chk("abort_dat", a_dat, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_pass", a_pass, 0);
    exp_dat_q.delete();
    repeat (2) @(posedge lfsr_clk);
    #1 resetn = 1'b1;

    // Run 3: fresh start after abort (paused mid-run when the pause port exists).
    push_run(1'b1);
`ifdef MISR_BIST_PAUSE_EN
    run_full(6);
`else
    run_full(-1);
`endif
    repeat (3) @(posedge lfsr_clk);
    #1;
    chk("final_pass_a", a_pass, 1);
    chk("c_never_en", c_en_seen, 0);
    chk("q_dat_empty", exp_dat_q.size(), 0);
    chk("q_pass_a_empty", exp_pass_a.size(), 0);
    chk("q_pass_b_empty", exp_pass_b.size(), 0);
    chk("q_pass_c_empty", exp_pass_c.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
